// File: rtl/sparse_cnn_layer_sched.sv
// Layer scheduler for the SparseCNN datapath. For each kernel it clears the datapath,
// loads the kernel weights, streams the feature map, then waits for and hands off the result.
module sparse_cnn_layer_sched #(
  parameter int INPUT_SIZE = 28,
  parameter int ADDR_W     = 10,
  parameter int KIDX_W     = 8,
  parameter int TIMEOUT    = 4096,
  parameter int TO_W       = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [KIDX_W-1:0] num_kernels,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              dp_clear,
  output logic              wgt_req,
  output logic [KIDX_W-1:0] wgt_sel,
  input  logic              wgt_ack,
  output logic              feat_rd,
  output logic [ADDR_W-1:0] feat_addr,
  output logic              feature_in_valid,
  input  logic              dp_out_valid,
  output logic              res_valid,
  output logic [KIDX_W-1:0] res_kidx,
  input  logic              res_ready
);

  localparam int PIXELS = INPUT_SIZE * INPUT_SIZE;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);
  localparam logic [TO_W-1:0]   LAST_TO  = TO_W'(TIMEOUT - 1);
  localparam logic [KIDX_W-1:0] KIDX_ZERO = {KIDX_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD_W = 3'd2,
    S_STREAM = 3'd3,
    S_WAIT   = 3'd4,
    S_RESULT = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t            state_r, state_s;
  logic [KIDX_W-1:0] kidx_r, kidx_s, nk_r;
  logic [ADDR_W-1:0] pix_r, pix_s;
  logic [TO_W-1:0]   to_r, to_s;

  logic              start_acc_s, abort_acc_s, res_fire_s, last_kidx_s;
  logic              busy_s, done_s, error_s, dp_clear_s, wgt_req_s, feat_rd_s, res_valid_s;
  logic [KIDX_W-1:0] wgt_sel_s, res_kidx_s;
  logic              busy_r, done_r, error_r, dp_clear_r, wgt_req_r, feat_rd_r, fiv_r, res_valid_r;
  logic [KIDX_W-1:0] wgt_sel_r, res_kidx_r;

  assign start_acc_s = (state_r == S_IDLE) && start;
  assign abort_acc_s = (state_r != S_IDLE) && abort;
  assign res_fire_s  = (state_r == S_RESULT) && res_ready && !abort_acc_s;
  assign last_kidx_s = (kidx_r == (nk_r - KIDX_W'(1)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_s = state_r;
    if (abort_acc_s) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && (num_kernels != KIDX_ZERO)) state_s = S_CLEAR;
          else                                      state_s = S_IDLE;
        end
        S_CLEAR:  state_s = S_LOAD_W;
        S_LOAD_W: begin
          if (wgt_ack) state_s = S_STREAM;
          else         state_s = S_LOAD_W;
        end
        S_STREAM: begin
          if (pix_r == LAST_PIX) state_s = S_WAIT;
          else                   state_s = S_STREAM;
        end
        S_WAIT: begin
          if (dp_out_valid)        state_s = S_RESULT;
          else if (to_r == LAST_TO) state_s = S_ERR;
          else                     state_s = S_WAIT;
        end
        S_RESULT: begin
          if (res_ready) state_s = last_kidx_s ? S_DONE : S_CLEAR;
          else           state_s = S_RESULT;
        end
        S_DONE:  state_s = S_IDLE;
        S_ERR:   state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Counter next values; pixel and timeout counters saturate and sit at 0 outside their state
  always_comb begin
    kidx_s = kidx_r;
    if (start_acc_s) begin
      kidx_s = KIDX_ZERO;
    end else if (res_fire_s && !last_kidx_s) begin
      kidx_s = kidx_r + KIDX_W'(1);
    end else begin
      kidx_s = kidx_r;
    end

    pix_s = pix_r;
    if (state_s != S_STREAM) begin
      pix_s = {ADDR_W{1'b0}};
    end else if ((state_r == S_STREAM) && (pix_r != LAST_PIX)) begin
      pix_s = pix_r + ADDR_W'(1);
    end else begin
      pix_s = pix_r;
    end

    to_s = to_r;
    if (state_s != S_WAIT) begin
      to_s = {TO_W{1'b0}};
    end else if ((state_r == S_WAIT) && (to_r != LAST_TO)) begin
      to_s = to_r + TO_W'(1);
    end else begin
      to_s = to_r;
    end
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    busy_s      = (state_s != S_IDLE);
    done_s      = (state_s == S_DONE) || (start_acc_s && (num_kernels == KIDX_ZERO));
    dp_clear_s  = (state_s == S_CLEAR) || abort_acc_s;
    wgt_req_s   = (state_s == S_LOAD_W);
    wgt_sel_s   = (state_s == S_LOAD_W) ? kidx_s : KIDX_ZERO;
    feat_rd_s   = (state_s == S_STREAM);
    res_valid_s = (state_s == S_RESULT);
    res_kidx_s  = (state_s == S_RESULT) ? kidx_s : KIDX_ZERO;
    error_s     = error_r;
    if (start_acc_s) begin
      error_s = 1'b0;
    end else if (state_s == S_ERR) begin
      error_s = 1'b1;
    end else begin
      error_s = error_r;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kidx_r      <= KIDX_ZERO;
      nk_r        <= KIDX_ZERO;
      pix_r       <= {ADDR_W{1'b0}};
      to_r        <= {TO_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      dp_clear_r  <= 1'b0;
      wgt_req_r   <= 1'b0;
      wgt_sel_r   <= KIDX_ZERO;
      feat_rd_r   <= 1'b0;
      fiv_r       <= 1'b0;
      res_valid_r <= 1'b0;
      res_kidx_r  <= KIDX_ZERO;
    end else begin
      kidx_r      <= kidx_s;
      nk_r        <= start_acc_s ? num_kernels : nk_r;
      pix_r       <= pix_s;
      to_r        <= to_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
      dp_clear_r  <= dp_clear_s;
      wgt_req_r   <= wgt_req_s;
      wgt_sel_r   <= wgt_sel_s;
      feat_rd_r   <= feat_rd_s;
      fiv_r       <= feat_rd_r;
      res_valid_r <= res_valid_s;
      res_kidx_r  <= res_kidx_s;
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign error            = error_r;
  assign dp_clear         = dp_clear_r;
  assign wgt_req          = wgt_req_r;
  assign wgt_sel          = wgt_sel_r;
  assign feat_rd          = feat_rd_r;
  assign feat_addr        = pix_r;
  assign feature_in_valid = fiv_r;
  assign res_valid        = res_valid_r;
  assign res_kidx         = res_kidx_r;

endmodule
